// File: rtl/cache_pkg.sv
// Shared cache geometry and the refill controller state encoding.
package cache_pkg;

  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 8;
  localparam int INDEX_W  = 3;
  localparam int WAY_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    VICTIM,
    WB,
    FILL,
    COMMIT
  } refillState_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill controller: picks a victim through the replacement block,
// writes it back when valid and dirty, fetches the missing line and commits it.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_W  = 8,
  parameter int LINE_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [TAG_W-1:0]           req_tag,
  input  logic [INDEX_W-1:0]         req_index,
  output logic [INDEX_W-1:0]         set_index,
  input  logic [NUM_WAYS-1:0]        set_valid,
  input  logic [NUM_WAYS-1:0]        set_dirty,
  input  logic [NUM_WAYS*TAG_W-1:0]  set_tags,
  input  logic [NUM_WAYS*LINE_W-1:0] set_data,
  output logic                       repl_replace,
  output logic [NUM_WAYS-1:0]        repl_valid_bits,
  input  logic [WAY_W-1:0]           repl_way,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [TAG_W+INDEX_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [LINE_W-1:0]          mem_rdata,
  output logic                       fill_we,
  output logic [WAY_W-1:0]           fill_way,
  output logic [TAG_W-1:0]           fill_tag,
  output logic [LINE_W-1:0]          fill_data,
  output logic                       resp_valid,
  output logic [15:0]                miss_count,
  output logic [15:0]                wb_count
);

  refillState_t            state;
  logic                    reqReadyReg;
  logic                    replReplaceReg;
  logic                    memReqReg;
  logic                    memWeReg;
  logic [TAG_W+INDEX_W-1:0] memAddrReg;
  logic [LINE_W-1:0]       memWdataReg;
  logic                    fillWeReg;
  logic                    respValidReg;
  logic [WAY_W-1:0]        wayReg;
  logic [TAG_W-1:0]        tagReg;
  logic [INDEX_W-1:0]      idxReg;
  logic [LINE_W-1:0]       rdataReg;

  logic [TAG_W-1:0]        wayTags [NUM_WAYS];
  logic [LINE_W-1:0]       wayData [NUM_WAYS];
  logic [TAG_W-1:0]        victimTag;
  logic [LINE_W-1:0]       victimData;
  logic                    wbNeeded;

  // Split the flat per-way buses so the victim mux is a plain array index.
  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : gWay
      assign wayTags[gi] = set_tags[gi*TAG_W +: TAG_W];
      assign wayData[gi] = set_data[gi*LINE_W +: LINE_W];
    end
  endgenerate

  assign victimTag  = wayTags[repl_way];
  assign victimData = wayData[repl_way];
  assign wbNeeded   = set_valid[repl_way] & set_dirty[repl_way];

  // The arrays are addressed by the incoming request only while waiting for one.
  assign set_index       = (state == IDLE) ? req_index : idxReg;
  assign repl_valid_bits = set_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      reqReadyReg    <= 1'b1;
      replReplaceReg <= 1'b0;
      memReqReg      <= 1'b0;
      memWeReg       <= 1'b0;
      memAddrReg     <= '0;
      memWdataReg    <= '0;
      fillWeReg      <= 1'b0;
      respValidReg   <= 1'b0;
      wayReg         <= '0;
      tagReg         <= '0;
      idxReg         <= '0;
      rdataReg       <= '0;
    end else begin
      replReplaceReg <= 1'b0;
      fillWeReg      <= 1'b0;
      respValidReg   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tagReg         <= req_tag;
            idxReg         <= req_index;
            reqReadyReg    <= 1'b0;
            replReplaceReg <= 1'b1;
            state          <= VICTIM;
          end
        end
        VICTIM: begin
          wayReg    <= repl_way;
          memReqReg <= 1'b1;
          if (wbNeeded) begin
            memWeReg    <= 1'b1;
            memAddrReg  <= {victimTag, idxReg};
            memWdataReg <= victimData;
            state       <= WB;
          end else begin
            memWeReg   <= 1'b0;
            memAddrReg <= {tagReg, idxReg};
            state      <= FILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            memWeReg   <= 1'b0;
            memAddrReg <= {tagReg, idxReg};
            state      <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            memReqReg    <= 1'b0;
            rdataReg     <= mem_rdata;
            fillWeReg    <= 1'b1;
            respValidReg <= 1'b1;
            state        <= COMMIT;
          end
        end
        COMMIT: begin
          reqReadyReg <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready    = reqReadyReg;
  assign repl_replace = replReplaceReg;
  assign mem_req      = memReqReg;
  assign mem_we       = memWeReg;
  assign mem_addr     = memAddrReg;
  assign mem_wdata    = memWdataReg;
  assign fill_we      = fillWeReg;
  assign resp_valid   = respValidReg;
  assign fill_way     = wayReg;
  assign fill_tag     = tagReg;
  assign fill_data    = rdataReg;

  sat_counter16 uMissCount (
    .clk   (clk),
    .reset (reset),
    .en    (state == COMMIT),
    .count (miss_count)
  );

  sat_counter16 uWbCount (
    .clk   (clk),
    .reset (reset),
    .en    ((state == WB) && mem_ack),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed and randomized misses against a transaction-level model of the
// set arrays, replacement choice and memory latency.
module tb_cache_refill_ctrl;

  localparam int TAG_W  = 8;
  localparam int LINE_W = 32;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [TAG_W-1:0]      req_tag = '0;
  logic [2:0]            req_index = '0;
  logic [2:0]            set_index;
  logic [3:0]            set_valid;
  logic [3:0]            set_dirty;
  logic [4*TAG_W-1:0]    set_tags;
  logic [4*LINE_W-1:0]   set_data;
  logic                  repl_replace;
  logic [3:0]            repl_valid_bits;
  logic [1:0]            repl_way = '0;
  logic                  mem_req;
  logic                  mem_we;
  logic [TAG_W+2:0]      mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic                  mem_ack = 1'b0;
  logic [LINE_W-1:0]     mem_rdata = '0;
  logic                  fill_we;
  logic [1:0]            fill_way;
  logic [TAG_W-1:0]      fill_tag;
  logic [LINE_W-1:0]     fill_data;
  logic                  resp_valid;
  logic [15:0]           miss_count;
  logic [15:0]           wb_count;

  logic                  satEn = 1'b0;
  logic [15:0]           satCount;

  // Model of the tag/data/state arrays seen by the controller.
  logic [3:0]            mValid [8];
  logic [3:0]            mDirty [8];
  logic [TAG_W-1:0]      mTag   [8][4];
  logic [LINE_W-1:0]     mData  [8][4];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int missExp = 0;
  int wbExp = 0;
  int lastAccept = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    set_valid = mValid[set_index];
    set_dirty = mDirty[set_index];
    set_tags  = '0;
    set_data  = '0;
    for (int w = 0; w < 4; w++) begin
      set_tags[w*TAG_W +: TAG_W]   = mTag[set_index][w];
      set_data[w*LINE_W +: LINE_W] = mData[set_index][w];
    end
  end

  cache_refill_ctrl #(.TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_tag         (req_tag),
    .req_index       (req_index),
    .set_index       (set_index),
    .set_valid       (set_valid),
    .set_dirty       (set_dirty),
    .set_tags        (set_tags),
    .set_data        (set_data),
    .repl_replace    (repl_replace),
    .repl_valid_bits (repl_valid_bits),
    .repl_way        (repl_way),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .fill_we         (fill_we),
    .fill_way        (fill_way),
    .fill_tag        (fill_tag),
    .fill_data       (fill_data),
    .resp_valid      (resp_valid),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
  );

  sat_counter16 satCnt (
    .clk   (clk),
    .reset (reset),
    .en    (satEn),
    .count (satCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomizeSet(input int idx);
    mValid[idx] = 4'($urandom);
    mDirty[idx] = 4'($urandom);
    for (int w = 0; w < 4; w++) begin
      mTag[idx][w]  = 8'($urandom);
      mData[idx][w] = $urandom;
    end
  endtask

  // One miss from request to the idle cycle after completion; called just after a negedge.
  task automatic doMiss(input logic [7:0] tag, input logic [2:0] idx, input logic [1:0] way,
                        input int wbLat, input int fillLat, input bit keepValid, input int expSpacing);
    bit                wbNeed;
    logic [10:0]       wbAddr;
    logic [31:0]       wbData;
    logic [31:0]       fillRd;
    bit                gotAccept;
    bit                readyBad;
    bit                seenWb;
    bit                seenFill;
    int                accept;
    int                expResp;
    int                replCnt;
    int                wbCyc;
    int                fillCyc;
    int                respCyc;
    int                c;
    req_valid = 1'b1;
    req_tag   = tag;
    req_index = idx;
    repl_way  = way;
    wbNeed    = mValid[idx][way] && mDirty[idx][way];
    wbAddr    = {mTag[idx][way], idx};
    wbData    = mData[idx][way];
    fillRd    = $urandom;
    gotAccept = 1'b0;
    for (int t = 0; t < 20 && !gotAccept; t++) begin
      if (req_ready) gotAccept = 1'b1;
      else @(negedge clk);
    end
    chk("accept", 64'(gotAccept), 64'd1);
    if (!gotAccept) return;
    accept = cyc + 1;
    if (expSpacing > 0) chk("spacing", 64'(accept - lastAccept), 64'(expSpacing));
    lastAccept = accept;
    expResp  = 1 + (wbNeed ? wbLat : 0) + fillLat + 1;
    replCnt  = 0;
    wbCyc    = 0;
    fillCyc  = 0;
    respCyc  = 0;
    readyBad = 1'b0;
    seenWb   = 1'b0;
    seenFill = 1'b0;
    c        = 0;
    while (respCyc == 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1 && !keepValid) req_valid = 1'b0;
      mem_ack = 1'b0;
      if (repl_replace) replCnt++;
      if (req_ready) readyBad = 1'b1;
      if (mem_req && mem_we) begin
        wbCyc++;
        if (!seenWb) begin
          seenWb = 1'b1;
          chk("wb_addr", 64'(mem_addr), 64'(wbAddr));
          chk("wb_data", 64'(mem_wdata), 64'(wbData));
        end
        if (wbCyc == wbLat) mem_ack = 1'b1;
      end else if (mem_req) begin
        fillCyc++;
        if (!seenFill) begin
          seenFill = 1'b1;
          chk("fill_addr", 64'(mem_addr), 64'({tag, idx}));
        end
        if (fillCyc == fillLat) begin
          mem_ack   = 1'b1;
          mem_rdata = fillRd;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        mem_ack = 1'b1;  // stray ack with nothing outstanding
      end
      if (resp_valid) begin
        respCyc = c;
        chk("fill_we", 64'(fill_we), 64'd1);
        chk("fill_way", 64'(fill_way), 64'(way));
        chk("fill_tag", 64'(fill_tag), 64'(tag));
        chk("fill_data", 64'(fill_data), 64'(fillRd));
      end
    end
    chk("resp_cycle", 64'(respCyc), 64'(expResp));
    chk("repl_pulses", 64'(replCnt), 64'd1);
    chk("wb_cycles", 64'(wbCyc), 64'(wbNeed ? wbLat : 0));
    chk("fill_cycles", 64'(fillCyc), 64'(fillLat));
    chk("busy_ready", 64'(readyBad), 64'd0);
    if (missExp < 65535) missExp++;
    if (wbNeed && wbExp < 65535) wbExp++;
    mValid[idx][way] = 1'b1;
    mDirty[idx][way] = 1'b0;
    mTag[idx][way]   = tag;
    mData[idx][way]  = fillRd;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("miss_count", 64'(miss_count), 64'(missExp));
    chk("wb_count", 64'(wb_count), 64'(wbExp));
    chk("ready_idle", 64'(req_ready), 64'd1);
    $display("miss tag=%02h idx=%0d way=%0d wb=%0d lat=%0d/%0d resp_cycle=%0d miss_count=%0d wb_count=%0d",
             tag, idx, way, wbNeed, wbLat, fillLat, respCyc, miss_count, wb_count);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit resetBad;
    bit reached;
    for (int s = 0; s < 8; s++) randomizeSet(s);

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_repl", 64'(repl_replace), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_outputs", 64'({mem_req, mem_we, fill_we, resp_valid, repl_replace}), 64'd0);
    chk("idle_latched", 64'({fill_way, fill_tag, fill_data, mem_addr}), 64'd0);
    chk("idle_counts", 64'({miss_count, wb_count}), 64'd0);

    // Clean victim, zero-wait memory.
    mValid[3] = 4'b1111;
    mDirty[3] = 4'b0000;
    doMiss(8'h5A, 3'd3, 2'd2, 1, 1, 1'b0, 0);

    // Dirty victim with 2-cycle memory latency.
    randomizeSet(5);
    mValid[5]    = 4'b1111;
    mDirty[5]    = 4'b0010;
    mTag[5][1]   = 8'h11;
    doMiss(8'hC3, 3'd5, 2'd1, 2, 2, 1'b0, 0);

    // Dirty but invalid victim: fill only.
    randomizeSet(0);
    mValid[0] = 4'b1110;
    mDirty[0] = 4'b0001;
    doMiss(8'h77, 3'd0, 2'd0, 1, 1, 1'b0, 0);

    // Randomized misses.
    for (int n = 0; n < 12; n++) begin
      int ri;
      ri = int'($urandom_range(0, 7));
      randomizeSet(ri);
      doMiss(8'($urandom), 3'(ri), 2'($urandom), int'($urandom_range(1, 3)),
             int'($urandom_range(1, 3)), 1'b0, 0);
    end

    // Back-to-back with req_valid held through the busy phase.
    for (int n = 0; n < 3; n++) begin
      int bi;
      bi = int'($urandom_range(0, 7));
      randomizeSet(bi);
      mDirty[bi] = 4'b0000;
      doMiss(8'($urandom), 3'(bi), 2'($urandom), 1, 1, (n < 2), (n == 0) ? 0 : 4);
    end

    // Reset while a fill read is outstanding.
    mValid[6] = 4'b1111;
    mDirty[6] = 4'b0000;
    req_valid = 1'b1;
    req_tag   = 8'hE4;
    req_index = 3'd6;
    repl_way  = 2'd3;
    reached   = 1'b0;
    for (int t = 0; t < 10 && !reached; t++) begin
      @(negedge clk);
      if (mem_req && !mem_we) reached = 1'b1;
    end
    chk("reach_fill", 64'(reached), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    resetBad  = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      if (fill_we || resp_valid || mem_req) resetBad = 1'b1;
    end
    mem_ack = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    if (fill_we || resp_valid || mem_req) resetBad = 1'b1;
    chk("arst_quiet", 64'(resetBad), 64'd0);
    chk("arst_ready_after", 64'(req_ready), 64'd1);
    chk("arst_counts", 64'({miss_count, wb_count}), 64'd0);
    $display("reset mid-fill mem_req=%0d req_ready=%0d miss_count=%0d wb_count=%0d",
             mem_req, req_ready, miss_count, wb_count);
    missExp = 0;
    wbExp   = 0;
    randomizeSet(6);
    doMiss(8'h3C, 3'd6, 2'd1, 1, 2, 1'b0, 0);

    // Saturation of the shared counter block.
    satEn = 1'b1;
    repeat (65534) @(negedge clk);
    chk("sat_fffe", 64'(satCount), 64'hFFFE);
    @(negedge clk);
    chk("sat_ffff", 64'(satCount), 64'hFFFF);
    repeat (5) @(negedge clk);
    chk("sat_hold", 64'(satCount), 64'hFFFF);
    satEn = 1'b0;
    $display("saturation count=%04h", satCount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-side controller for the 4-way, 8-set cache that drives the FIFO replacement block. On each miss accepted from the lookup stage, it pulses the replacement request and captures the chosen victim way. If the victim is valid and dirty, it writes the victim back to memory. It then fetches the missing line, writes it into the chosen way and returns a completion pulse to the lookup stage.

## Interface
Parameters:
- TAG_W, 8, tag width; line address is {tag, index}, ADDR_W = TAG_W+3
- LINE_W, 32, cache line data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  miss request from lookup stage
- req_ready  out  1  high only in IDLE
- req_tag  in  TAG_W  missing line tag
- req_index  in  3  missing line set index
- set_index  out  3  set address to tag/data arrays and replacement block
- set_valid  in  4  valid bits of set_index (combinational array read)
- set_dirty  in  4  dirty bits of set_index
- set_tags  in  4*TAG_W  way tags of set_index, way 0 in LSBs
- set_data  in  4*LINE_W  way data of set_index, way 0 in LSBs
- repl_replace  out  1  one-cycle replacement request (priority update)
- repl_valid_bits  out  4  equals set_valid
- repl_way  in  2  victim way from replacement block (combinational)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = writeback, 0 = fill read
- mem_addr  out  ADDR_W  line address
- mem_wdata  out  LINE_W  writeback data
- mem_ack  in  1  memory accept/complete; rdata valid this cycle
- mem_rdata  in  LINE_W  fill data
- fill_we  out  1  one-cycle array write strobe
- fill_way  out  2  way written
- fill_tag  out  TAG_W  tag written; valid set, dirty cleared by array
- fill_data  out  LINE_W  line written
- resp_valid  out  1  one-cycle miss-complete pulse
- miss_count  out  16  saturating count of completed misses
- wb_count  out  16  saturating count of writebacks

## Operation
- States: IDLE, VICTIM, WB, FILL, COMMIT.
- IDLE:
  - req_ready=1.
  - set_index=req_index.
  - On req_valid: latch tag and index, go to VICTIM.
- VICTIM (exactly 1 cycle):
  - repl_replace=1; set_index=latched index.
  - At the edge, latch way=repl_way, vtag=set_tags[way] and vdata=set_data[way].
  - Set wb_needed = set_valid[way] & set_dirty[way]. Dirty without valid is no writeback.
  - Next state is WB if wb_needed, else FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr={vtag,index}, mem_wdata=vdata.
  - On mem_ack: wb_count++ and go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req tag,index}.
  - On mem_ack: latch mem_rdata and go to COMMIT.
- COMMIT (1 cycle):
  - fill_we=1, resp_valid=1, fill_way=way, fill_tag=req tag, fill_data=latched rdata.
  - miss_count++; go to IDLE.
- Counters saturate at 16'hFFFF; no wrap.
- mem_ack while mem_req=0 is ignored.
- mem_req deasserts the cycle after mem_ack.
- req_valid outside IDLE is ignored; the requester holds it until req_ready.

## Timing
- Reset (async assert, sync deassert by system):
  - State IDLE.
  - All outputs 0 except req_ready=1, which follows IDLE.
  - Counters 0; latched way, tag and data 0.
- Reset mid-transaction:
  - FSM returns to IDLE immediately and mem_req drops asynchronously.
  - The outstanding memory access is abandoned, and no fill_we or resp_valid occurs.
- Accept at edge E0. repl_replace is high in cycle E0..E1.
- Zero-wait memory, no writeback: mem_req in cycle 2, fill_we/resp_valid in cycle 3.
- With writeback: resp_valid in cycle 4. Each memory wait cycle adds 1.
- repl_replace is exactly one pulse per accepted miss, never during WB, FILL or COMMIT.
- set_index is stable from VICTIM through COMMIT.
- Back-to-back: a new request is accepted the cycle after COMMIT (IDLE), so the minimum miss-to-miss spacing is 4 cycles.

## Structure
- Shared package cache_pkg holds:
  - NUM_WAYS=4, NUM_SETS=8, INDEX_W=3, WAY_W=2
  - the FSM state encoding (IDLE/VICTIM/WB/FILL/COMMIT)
- Sub-module sat_counter16 (enable, async active-low reset, saturating) is instantiated twice, for miss_count and wb_count.
- Victim select is an internal 4:1 mux on the way index; no separate module.

## Test plan
- Clean victim:
  - Stimulus: set_valid=4'b1111, set_dirty=0, repl_way=2, req_tag=8'h5A, req_index=3, mem_ack on the first request cycle.
  - Response: one repl_replace, a single mem read at addr {8'h5A,3'd3}, then fill_we with fill_way=2, resp_valid in cycle 3, miss_count=1.
- Dirty victim:
  - Stimulus: set_dirty[1]=1, repl_way=1, victim tag 8'h11, 2-cycle ack latency.
  - Response: a write to {8'h11,idx} carrying set_data way 1, then the fill read; wb_count=1, resp_valid in cycle 6.
- Invalid-but-dirty victim:
  - Stimulus: set_valid[0]=0, set_dirty[0]=1, repl_way=0.
  - Response: no writeback, fill only, wb_count=0.
- Reset mid-operation:
  - Stimulus: assert reset while in FILL with mem_req=1.
  - Response: mem_req=0 immediately, no fill_we or resp_valid, req_ready=1 after release, counters 0.
- Busy and saturation:
  - Stimulus: hold req_valid through the busy phase and issue 3 back-to-back misses.
  - Response: each is accepted only in IDLE, 4 cycles apart. A preloaded miss_count of 16'hFFFF stays at 16'hFFFF.
